// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module : dbus_pkg
// Desc   : Framer state encodings, TI link command codes, payload lookup.
// Rev    : 1.0  initial release
// ============================================================================
package dbus_pkg;

  typedef enum logic [2:0] {
    S_MID  = 3'd0,
    S_CMD  = 3'd1,
    S_LENL = 3'd2,
    S_LENH = 3'd3,
    S_DATA = 3'd4,
    S_CKL  = 3'd5,
    S_CKH  = 3'd6
  } framer_state_t;

  localparam logic [7:0] CMD_VAR  = 8'h06;
  localparam logic [7:0] CMD_DATA = 8'h15;
  localparam logic [7:0] CMD_SKIP = 8'h36;
  localparam logic [7:0] CMD_DEL  = 8'h88;
  localparam logic [7:0] CMD_REQ  = 8'hA2;
  localparam logic [7:0] CMD_RTS  = 8'hC9;
  localparam logic [7:0] CMD_ACK  = 8'h56;
  localparam logic [7:0] CMD_CTS  = 8'h09;

  // Commands whose length field announces a payload plus 16-bit checksum.
  function automatic logic has_payload(input logic [7:0] cmd);
    return (cmd == CMD_VAR)  || (cmd == CMD_DATA) || (cmd == CMD_SKIP) ||
           (cmd == CMD_DEL)  || (cmd == CMD_REQ)  || (cmd == CMD_RTS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_pkt_sum.sv
`default_nettype none
// ============================================================================
// Module : dbus_pkt_sum
// Desc   : 16-bit wrapping payload accumulator with clear/add and compare.
// Rev    : 1.0  initial release
// ============================================================================
module dbus_pkt_sum (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [7:0]  i_byte,
  input  logic [15:0] i_ck,
  output logic        o_match
);

  logic [15:0] r_sum;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sum <= 16'd0;
    end else if (i_clr) begin
      r_sum <= 16'd0;
    end else if (i_add) begin
      r_sum <= r_sum + {8'd0, i_byte};
    end
  end

  assign o_match = (i_ck == r_sum);

endmodule
`default_nettype wire

// File: rtl/dbus_packet_framer.sv
`default_nettype none
// ============================================================================
// Module : dbus_packet_framer
// Desc   : dbus byte forwarder with TI link packet framing, checksum and timeout.
// Rev    : 1.0  initial release
// ============================================================================
module dbus_packet_framer
  import dbus_pkg::*;
#(
  parameter int c_TIMEOUTBITS = 20
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_avail,
  input  logic [7:0]  i_data,
  output logic        o_read,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_pkt_done,
  output logic        o_ck_err,
  output logic        o_timeout,
  output logic [7:0]  o_mid,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_pkt_count
);

  // Fires on the edge where the idle counter would reach all-ones.
  localparam logic [c_TIMEOUTBITS-1:0] c_IDLE_FIRE = ~c_TIMEOUTBITS'(1);

  framer_state_t            r_state;
  framer_state_t            w_state_next;
  logic                     r_avail;
  logic [7:0]               r_mid_cur;
  logic [7:0]               r_cmd_cur;
  logic [7:0]               r_len_lo;
  logic [7:0]               r_ck_lo;
  logic [15:0]              r_rem;
  logic [c_TIMEOUTBITS-1:0] r_idle;
  logic [15:0]              w_len;
  logic                     w_free;
  logic                     w_accept;
  logic                     w_done;
  logic                     w_ck_err;
  logic                     w_timeout;
  logic                     w_sum_clr;
  logic                     w_sum_add;
  logic                     w_sum_match;

  assign w_free   = !o_valid || i_ready;
  assign w_accept = r_avail && !o_read && w_free;
  assign w_len    = {i_data, r_len_lo};

  dbus_pkt_sum u_sum (
    .i_clock  (i_clock),
    .i_resetn (i_resetn),
    .i_clr    (w_sum_clr),
    .i_add    (w_sum_add),
    .i_byte   (i_data),
    .i_ck     ({i_data, r_ck_lo}),
    .o_match  (w_sum_match)
  );

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_ck_err     = 1'b0;
    w_timeout    = 1'b0;
    w_sum_clr    = 1'b0;
    w_sum_add    = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_MID:  w_state_next = S_CMD;
        S_CMD:  w_state_next = S_LENL;
        S_LENL: w_state_next = S_LENH;
        S_LENH: begin
          if (has_payload(r_cmd_cur) && (w_len != 16'd0)) begin
            w_sum_clr    = 1'b1;
            w_state_next = S_DATA;
          end else begin
            w_done       = 1'b1;
            w_state_next = S_MID;
          end
        end
        S_DATA: begin
          w_sum_add = 1'b1;
          if (r_rem == 16'd1) w_state_next = S_CKL;
        end
        S_CKL:  w_state_next = S_CKH;
        S_CKH: begin
          w_done       = w_sum_match;
          w_ck_err     = !w_sum_match;
          w_state_next = S_MID;
        end
        default: w_state_next = S_MID;
      endcase
    end else if ((r_state != S_MID) && (r_idle == c_IDLE_FIRE)) begin
      w_timeout    = 1'b1;
      w_state_next = S_MID;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_MID;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Four-phase upstream handshake and the one-entry holding register.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_avail <= 1'b0;
      o_read  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= 8'd0;
    end else begin
      r_avail <= i_avail;
      if (w_accept) begin
        o_read <= 1'b1;
      end else if (!r_avail) begin
        o_read <= 1'b0;
      end
      if (w_accept) begin
        o_valid <= 1'b1;
        o_data  <= i_data;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_mid_cur   <= 8'd0;
      r_cmd_cur   <= 8'd0;
      r_len_lo    <= 8'd0;
      r_ck_lo     <= 8'd0;
      r_rem       <= 16'd0;
      r_idle      <= '0;
      o_pkt_done  <= 1'b0;
      o_ck_err    <= 1'b0;
      o_timeout   <= 1'b0;
      o_mid       <= 8'd0;
      o_cmd       <= 8'd0;
      o_pkt_count <= 16'd0;
    end else begin
      o_pkt_done <= w_done;
      o_ck_err   <= w_ck_err;
      o_timeout  <= w_timeout;
      if (w_done || w_ck_err) begin
        o_pkt_count <= o_pkt_count + 16'd1;
        o_mid       <= r_mid_cur;
        o_cmd       <= r_cmd_cur;
      end
      if (w_accept || w_timeout || (r_state == S_MID)) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + c_TIMEOUTBITS'(1);
      end
      if (w_accept) begin
        case (r_state)
          S_MID:   r_mid_cur <= i_data;
          S_CMD:   r_cmd_cur <= i_data;
          S_LENL:  r_len_lo  <= i_data;
          S_LENH:  r_rem     <= w_len;
          S_DATA:  r_rem     <= r_rem - 16'd1;
          S_CKL:   r_ck_lo   <= i_data;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_packet_framer.sv
`default_nettype none
// ============================================================================
// Module : tb_dbus_packet_framer
// Desc   : Directed plus randomized bench with a packet-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dbus_packet_framer;

  localparam int TOBITS     = 4;
  localparam int IDLE_LIMIT = (1 << TOBITS) - 1;

  typedef logic [7:0] bq_t[$];

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        avail  = 1'b0;
  logic [7:0]  din    = 8'd0;
  logic        ready  = 1'b1;
  logic        read;
  logic [7:0]  dout;
  logic        valid;
  logic        pkt_done;
  logic        ck_err;
  logic        tmo;
  logic [7:0]  mid;
  logic [7:0]  cmd;
  logic [15:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rand_ready  = 1'b0;
  logic       ready_force = 1'b1;
  logic [7:0] cur_byte    = 8'd0;
  int         n_sent      = 0;

  // reference model state
  logic [7:0]  pkt[$];
  logic        m_valid, pend_xfer, prev_read, acc;
  logic [7:0]  m_data, m_mid, m_cmd;
  logic [15:0] m_count;
  logic        e_done, e_ck, e_to;
  int          idle, n_acc, n_xfer;
  int          n_done_seen = 0, n_ck_seen = 0, n_to_seen = 0;

  dbus_packet_framer #(.c_TIMEOUTBITS(TOBITS)) dut (
    .i_clock     (clk),
    .i_resetn    (resetn),
    .i_avail     (avail),
    .i_data      (din),
    .o_read      (read),
    .o_data      (dout),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_pkt_done  (pkt_done),
    .o_ck_err    (ck_err),
    .o_timeout   (tmo),
    .o_mid       (mid),
    .o_cmd       (cmd),
    .o_pkt_count (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  function automatic logic has_pay(input logic [7:0] c);
    return c == 8'h06 || c == 8'h15 || c == 8'h36 || c == 8'h88 || c == 8'hA2 || c == 8'hC9;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a packet is complete once its byte count matches what the header announces.
  always @(negedge clk) begin
    if (!resetn) begin
      pkt.delete();
      m_valid = 1'b0; pend_xfer = 1'b0; prev_read = 1'b0; m_data = 8'd0;
      m_mid = 8'd0; m_cmd = 8'd0; m_count = 16'd0; idle = 0; n_acc = 0; n_xfer = 0;
    end else begin
      acc = read && !prev_read;
      e_done = 1'b0; e_ck = 1'b0; e_to = 1'b0;
      if (pend_xfer) n_xfer++;
      if (acc) begin
        check("accept_when_free", 32'(!m_valid || pend_xfer), 32'd1);
        m_valid = 1'b1;
        m_data  = cur_byte;
        n_acc++;
        idle = 0;
        pkt.push_back(cur_byte);
        if (pkt.size() >= 4) begin
          automatic int ln = int'({pkt[3], pkt[2]});
          if (!has_pay(pkt[1]) || ln == 0) begin
            if (pkt.size() == 4) e_done = 1'b1;
          end else if (pkt.size() == 6 + ln) begin
            automatic logic [15:0] s = 16'd0;
            for (int k = 0; k < ln; k++) s = s + 16'(pkt[4+k]);
            if ({pkt[5+ln], pkt[4+ln]} == s) e_done = 1'b1;
            else e_ck = 1'b1;
          end
          if (e_done || e_ck) begin
            m_count = m_count + 16'd1;
            m_mid = pkt[0];
            m_cmd = pkt[1];
            pkt.delete();
          end
        end
      end else begin
        if (pend_xfer) m_valid = 1'b0;
        if (pkt.size() > 0) begin
          idle++;
          if (idle == IDLE_LIMIT) begin
            e_to = 1'b1;
            pkt.delete();
          end
        end
      end
      check("o_valid", 32'(valid), 32'(m_valid));
      if (m_valid) check("o_data", 32'(dout), 32'(m_data));
      check("o_pkt_done", 32'(pkt_done), 32'(e_done));
      check("o_ck_err", 32'(ck_err), 32'(e_ck));
      check("o_timeout", 32'(tmo), 32'(e_to));
      check("o_pkt_count", 32'(cnt), 32'(m_count));
      check("o_mid", 32'(mid), 32'(m_mid));
      check("o_cmd", 32'(cmd), 32'(m_cmd));
      if (pkt_done) n_done_seen++;
      if (ck_err) n_ck_seen++;
      if (tmo) n_to_seen++;
      pend_xfer = m_valid && ready;
      prev_read = read;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b);
    cur_byte = b;
    din      = b;
    avail    = 1'b1;
    n_sent++;
  endtask

  task automatic finish_hs();
    automatic logic got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      tick();
      got = read;
    end
    check("read_rise_in_budget", 32'(got), 32'd1);
    avail = 1'b0;
    got = 1'b1;
    for (int k = 0; k < 50 && got; k++) begin
      tick();
      got = read;
    end
    check("read_fall_in_budget", 32'(got), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    offer(b);
    finish_hs();
  endtask

  task automatic send_pkt(input bq_t b, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  bq_t        pk;
  logic [7:0] cmds [9] = '{8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9, 8'h56, 8'h09, 8'h00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (3) tick();
    check("rst_ctrl", 32'({read, valid, pkt_done, ck_err, tmo}), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_mid_cmd", 32'({mid, cmd}), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    resetn = 1'b1;
    tick();

    pk = '{8'h73, 8'h56, 8'h00, 8'h00};
    send_pkt(pk, pk.size(), 0); drain();
    check("ack_count", 32'(cnt), 32'd1);
    check("ack_mid", 32'(mid), 32'h73);
    check("ack_cmd", 32'(cmd), 32'h56);
    check("ack_done_pulses", 32'(n_done_seen), 32'd1);

    pk = '{8'h73, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
    send_pkt(pk, pk.size(), 1); drain();
    check("data_count", 32'(cnt), 32'd2);
    check("data_done_pulses", 32'(n_done_seen), 32'd2);
    check("data_no_ck_err", 32'(n_ck_seen), 32'd0);

    pk = '{8'h73, 8'h15, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h00};
    send_pkt(pk, pk.size(), 1); drain();
    check("bad_ck_count", 32'(cnt), 32'd3);
    check("bad_ck_pulses", 32'(n_ck_seen), 32'd1);
    check("bad_ck_no_done", 32'(n_done_seen), 32'd2);

    pk = '{8'h73, 8'h15, 8'h00, 8'h00};
    send_pkt(pk, pk.size(), 0); drain();
    check("len0_count", 32'(cnt), 32'd4);
    check("len0_done", 32'(n_done_seen), 32'd3);

    // Downstream stall with the next packet's mid byte on offer.
    pk = '{8'h73, 8'h56, 8'h00};
    send_pkt(pk, pk.size(), 0);
    ready_force = 1'b0;
    send_byte(8'h00);
    offer(8'h73);
    repeat (20) tick();
    check("stall_read_low", 32'(read), 32'd0);
    check("stall_valid", 32'(valid), 32'd1);
    check("stall_data_held", 32'(dout), 32'h00);
    check("stall_count", 32'(cnt), 32'd5);
    ready_force = 1'b1;
    finish_hs();

    send_byte(8'h15);
    repeat (25) tick();
    check("timeout_pulses", 32'(n_to_seen), 32'd1);
    check("timeout_count", 32'(cnt), 32'd5);

    pk = '{8'h73, 8'h56, 8'h00, 8'h00};
    send_pkt(pk, pk.size(), 0); drain();
    check("post_to_count", 32'(cnt), 32'd6);
    check("post_to_cmd", 32'(cmd), 32'h56);
    check("post_to_done", 32'(n_done_seen), 32'd5);

    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      automatic int          ci = $urandom_range(0, 8);
      automatic logic [7:0]  c  = (ci == 8) ? 8'($urandom) : cmds[ci];
      automatic logic [15:0] ln;
      automatic logic [15:0] s  = 16'd0;
      ln = has_pay(c) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      pk.delete();
      pk.push_back(8'($urandom));
      pk.push_back(c);
      pk.push_back(ln[7:0]);
      pk.push_back(ln[15:8]);
      if (has_pay(c) && ln != 16'd0) begin
        for (int k = 0; k < int'(ln); k++) begin
          automatic logic [7:0] d = 8'($urandom);
          pk.push_back(d);
          s = s + 16'(d);
        end
        if ($urandom_range(0, 3) == 0) s = s + 16'd1 + 16'($urandom_range(0, 100));
        pk.push_back(s[7:0]);
        pk.push_back(s[15:8]);
      end
      if ($urandom_range(0, 7) == 0) begin
        send_pkt(pk, $urandom_range(1, pk.size() - 1), 2);
        repeat (20) tick();
      end else begin
        send_pkt(pk, pk.size(), 3);
      end
    end
    rand_ready = 1'b0;
    repeat (30) tick();
    check("rand_all_accepted", 32'(n_acc), 32'(n_sent));
    check("rand_all_forwarded", 32'(n_xfer), 32'(n_acc));

    // Asynchronous reset with a partial packet and a held byte.
    pk = '{8'h55, 8'h15, 8'h03, 8'h00};
    send_pkt(pk, pk.size(), 0);
    ready_force = 1'b0;
    send_byte(8'h01);
    repeat (2) tick();
    resetn = 1'b0;
    n_sent = 0;
    #1;
    check("arst_ctrl", 32'({read, valid, pkt_done, ck_err, tmo}), 32'd0);
    check("arst_data", 32'(dout), 32'd0);
    check("arst_mid_cmd", 32'({mid, cmd}), 32'd0);
    check("arst_count", 32'(cnt), 32'd0);
    ready_force = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    pk = '{8'h42, 8'h09, 8'h00, 8'h00};
    send_pkt(pk, pk.size(), 0); drain();
    check("after_rst_count", 32'(cnt), 32'd1);
    check("after_rst_mid", 32'(mid), 32'h42);
    check("after_rst_cmd", 32'(cmd), 32'h09);
    check("after_rst_forwarded", 32'(n_xfer), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
